uart_rx: RTL and testbench

UART receiver: deserialises an asynchronous 8N1-style serial line (`rxd`) into parallel words on an AXI-Stream master port. Sits opposite the team's `uart_tx` on the same link and shares its clock-enable timebase generator, but is driven by an oversampling tick instead of a 1x baud tick. Detects start bits with glitch rejection, samples each bit at mid-period, and flags framing errors and overruns.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled serial receiver (start, DATA_WIDTH bits LSB first, stop)
// with glitch-rejecting start detection, an AXI-Stream output register, and
// one-cycle framing-error and overrun pulses.
module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clk_en,
   input  logic                  rxd,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  frame_error,
   output logic                  overrun_error,
   output logic                  busy
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state, state_n;
   logic [TW-1:0]         tick_cnt, tick_cnt_n;
   logic [BW-1:0]         bit_cnt, bit_cnt_n;
   logic                  armed, armed_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic                  rxd_p0, rxd_p1, rxd_s;
   logic                  deliver, stop_bad;

   // Two-flop synchroniser; both stages idle high so reset looks like an idle line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
      end else begin
         rxd_p0 <= rxd;
         rxd_p1 <= rxd_p0;
      end
   end

   assign rxd_s = rxd_p1;
   assign busy  = (state != IDLE);

   // FSM state, tick/bit counters, arming flag and shift register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         armed    <= 1'b0;
         shreg    <= '0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_cnt_n;
         bit_cnt  <= bit_cnt_n;
         armed    <= armed_n;
         shreg    <= shreg_n;
      end
   end

   // Next-state logic; everything advances only on an oversample tick
   always_comb begin
      state_n    = state;
      tick_cnt_n = tick_cnt;
      bit_cnt_n  = bit_cnt;
      armed_n    = armed;
      shreg_n    = shreg;
      deliver    = 1'b0;
      stop_bad   = 1'b0;
      if (clk_en) begin
         case (state)
            IDLE: begin
               // A start is only accepted after the line has been seen high,
               // so a break or a held-low line cannot retrigger reception.
               if (armed && !rxd_s) begin
                  state_n    = START;
                  tick_cnt_n = '0;
                  armed_n    = 1'b0;
               end else if (rxd_s) begin
                  armed_n = 1'b1;
               end
            end
            START: begin
               if (tick_cnt == TICK_MID) begin
                  tick_cnt_n = '0;
                  if (!rxd_s) begin
                     state_n   = DATA;
                     bit_cnt_n = '0;
                  end else begin
                     state_n = IDLE;   // line back high at mid-start: glitch
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
            DATA: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_n                 = '0;
                  shreg_n                    = shreg >> 1;
                  shreg_n[DATA_WIDTH-1]      = rxd_s;
                  if (bit_cnt == BIT_LAST) begin
                     state_n   = STOP;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt + 1'b1;
                  end
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
            STOP: begin
               // Leave at mid-stop-bit to keep half a bit of resync margin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_n = '0;
                  state_n    = IDLE;
                  deliver    = rxd_s;
                  stop_bad   = !rxd_s;
               end else begin
                  tick_cnt_n = tick_cnt + 1'b1;
               end
            end
            default: begin
               state_n    = IDLE;
               tick_cnt_n = '0;
            end
         endcase
      end
   end

   // Output register: delivery loads the word; a handshake frees it unless a
   // new word lands in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         frame_error   <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         frame_error   <= stop_bad;
         overrun_error <= deliver & m_axis_tvalid & ~m_axis_tready;
         if (deliver) begin
            m_axis_tdata  <= shreg;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames on rxd; a word-level model (queue of words that
// must appear at the AXI-Stream handshake, plus expected error-pulse counts)
// is checked by a monitor every cycle.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int DW = 8;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_en;
   logic          rxd;
   logic          tready;
   logic [DW-1:0] tdata;
   logic          tvalid, ferr, oerr, busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int div     = 1;
   int fe_cnt  = 0;
   int ov_cnt  = 0;
   int busy_cyc = 0;
   int tv_rise_cyc = -1;
   logic tv_d = 1'b0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .rxd(rxd),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .frame_error(ferr), .overrun_error(oerr), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Serialise one frame: start 0, data LSB first, stop bit; per = clk cycles/bit.
   // rdy_at >= 0 raises tready that many cycles after the falling edge.
   task automatic send(input logic [DW-1:0] b, input logic stop, input int per,
                       input int rdy_at, output int t_fall);
      logic [DW+1:0] fr;
      fr = {stop, b, 1'b0};
      @(negedge clk);
      t_fall = cyc;
      for (int n = 0; n < (DW + 2) * per; n++) begin
         rxd = fr[n / per];
         if (n == rdy_at) tready = 1'b1;
         @(negedge clk);
      end
      if (stop) rxd = 1'b1;
   endtask

   task automatic drain(input string name, input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tf, fe0, ov0, b0, d;
      logic [DW+1:0] fr;
      reset  = 1'b0;
      rxd    = 1'b1;
      tready = 1'b1;
      clk_en = 1'b0;

      fork
         // clk_en generator: one pulse every div cycles
         begin
            int k = 0;
            forever begin
               @(negedge clk);
               k = (k + 1 >= div) ? 0 : k + 1;
               clk_en = (k == 0);
            end
         end
         // Monitor: error pulse counting and word checks at each handshake
         begin
            forever begin
               @(negedge clk);
               #1;
               if (reset === 1'b0) begin
                  if (ferr === 1'b1) fe_cnt++;
                  if (oerr === 1'b1) ov_cnt++;
                  if (busy === 1'b1) busy_cyc++;
                  if (tvalid === 1'b1 && tv_d !== 1'b1) tv_rise_cyc = cyc;
                  if (tvalid === 1'b1 && tready === 1'b1) begin
                     if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL handshake: unexpected word %02h, none expected", tdata);
                     end else begin
                        check("tdata", tdata, exp_q.pop_front());
                     end
                  end
               end
               tv_d = tvalid;
            end
         end
      join_none

      // Reset / idle
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("rst_tvalid", tvalid, 0);
      check("rst_tdata", tdata, 0);
      check("rst_ferr", ferr, 0);
      check("rst_oerr", oerr, 0);
      check("rst_busy", busy, 0);
      idle(3);
      reset = 1'b0;
      b0 = busy_cyc;
      d = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tvalid !== 1'b0) d++;
      end
      check("idle_tvalid_cycles", d, 0);
      check("idle_busy_cycles", busy_cyc - b0, 0);

      // Nominal back-to-back frames
      fe0 = fe_cnt; ov0 = ov_cnt;
      tv_rise_cyc = -1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      send(8'hA5, 1'b1, OS, -1, tf);
      d = tv_rise_cyc - tf;
      check("latency_154pm1", (d >= 153 && d <= 155), 1);
      send(8'h3C, 1'b1, OS, -1, tf);
      drain("nominal_drain", 300);
      check("nominal_ferr", fe_cnt - fe0, 0);
      check("nominal_oerr", ov_cnt - ov0, 0);

      // Glitch on the line
      idle(16);
      fe0 = fe_cnt; b0 = busy_cyc;
      @(negedge clk);
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(40);
      check("glitch_busy_brief", (busy_cyc - b0 > 0) && (busy_cyc - b0 < OS), 1);
      check("glitch_ferr", fe_cnt - fe0, 0);
      check("glitch_no_tvalid", tvalid, 0);
      exp_q.push_back(8'h5A);
      send(8'h5A, 1'b1, OS, -1, tf);
      drain("glitch_next_drain", 300);

      // Framing error followed by a long break
      idle(16);
      fe0 = fe_cnt;
      send(8'h3C, 1'b0, OS, -1, tf);
      b0 = busy_cyc;
      idle(40 * OS);
      check("break_no_restart", busy_cyc - b0, 0);
      check("ferr_one_pulse", fe_cnt - fe0, 1);
      check("ferr_no_tvalid", tvalid, 0);
      rxd = 1'b1;
      idle(2 * OS);
      exp_q.push_back(8'h81);
      send(8'h81, 1'b1, OS, -1, tf);
      drain("after_break_drain", 300);
      check("after_break_ferr", fe_cnt - fe0, 1);

      // Overrun under backpressure
      idle(16);
      ov0 = ov_cnt;
      tready = 1'b0;
      exp_q.push_back(8'h22);
      send(8'h11, 1'b1, OS, -1, tf);
      send(8'h22, 1'b1, OS, -1, tf);
      idle(4);
      check("ovr_one_pulse", ov_cnt - ov0, 1);
      check("ovr_tvalid_held", tvalid, 1);
      check("ovr_tdata_new", tdata, 8'h22);
      tready = 1'b1;
      drain("ovr_drain", 20);
      idle(2);
      check("ovr_tvalid_cleared", tvalid, 0);

      // Delivery coinciding with the handshake: no overrun
      ov0 = ov_cnt;
      tready = 1'b0;
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      send(8'h33, 1'b1, OS, -1, tf);
      idle(16);
      send(8'h44, 1'b1, OS, 154, tf);
      drain("same_cycle_drain", 40);
      check("same_cycle_no_ovr", ov_cnt - ov0, 0);

      // Throttled tick, baud skew +/-3%
      div = 4;
      idle(64);
      fe0 = fe_cnt; ov0 = ov_cnt;
      exp_q.push_back(8'h00);
      send(8'h00, 1'b1, 66, -1, tf);
      idle(128);
      exp_q.push_back(8'hFF);
      send(8'hFF, 1'b1, 62, -1, tf);
      drain("skew_drain", 1000);
      check("skew_ferr", fe_cnt - fe0, 0);
      check("skew_oerr", ov_cnt - ov0, 0);

      // Reset mid-byte, then a clean frame
      idle(128);
      fr = {1'b1, 8'h96, 1'b0};
      @(negedge clk);
      for (int n = 0; n < 4 * 4 * OS; n++) begin
         rxd = fr[n / (4 * OS)];
         @(negedge clk);
      end
      check("midbyte_busy_before", busy, 1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("midbyte_rst_busy", busy, 0);
      check("midbyte_rst_tvalid", tvalid, 0);
      check("midbyte_rst_ferr", ferr, 0);
      @(negedge clk);
      rxd = 1'b1;
      idle(3);
      reset = 1'b0;
      fe0 = fe_cnt; b0 = busy_cyc;
      idle(200);
      check("midbyte_no_flags", fe_cnt - fe0, 0);
      check("midbyte_quiet", busy_cyc - b0, 0);
      exp_q.push_back(8'h96);
      send(8'h96, 1'b1, 4 * OS, -1, tf);
      drain("midbyte_next_drain", 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
